// File: rtl/xcore_if_bpu_ckpt_if.sv
// rtl/xcore_if_bpu_ckpt_if.sv - BPU push / writeback / GHR commit bundle for the branch checkpoint queue
//
// Purpose: groups the prediction push channel, the resolution channel and the
// back-end GHR update port of xcore_if_bpu_ckpt into one interface.
// Ports (master = fetch/back-end side, slave = checkpoint queue):
//   i_bpu_req, i_bpu_taken, i_ghr_val   prediction push (master -> slave)
//   o_bpu_ready                         push accepted this cycle (slave -> master)
//   i_wb_req, i_wb_taken, i_wb_flush    resolution / flush (master -> slave)
//   o_cmt_req, o_cmt_ghr, o_cmt_target,
//   o_cmt_ghr_val                       GHR update port (slave -> master)
interface xcore_if_bpu_ckpt_if #(
  parameter int GHRLEN = 2
) ();
  logic              i_bpu_req;
  logic              i_bpu_taken;
  logic [GHRLEN-1:0] i_ghr_val;
  logic              o_bpu_ready;
  logic              i_wb_req;
  logic              i_wb_taken;
  logic              i_wb_flush;
  logic              o_cmt_req;
  logic              o_cmt_ghr;
  logic              o_cmt_target;
  logic [GHRLEN-1:0] o_cmt_ghr_val;

  modport master (
    output i_bpu_req, i_bpu_taken, i_ghr_val, i_wb_req, i_wb_taken, i_wb_flush,
    input  o_bpu_ready, o_cmt_req, o_cmt_ghr, o_cmt_target, o_cmt_ghr_val
  );

  modport slave (
    input  i_bpu_req, i_bpu_taken, i_ghr_val, i_wb_req, i_wb_taken, i_wb_flush,
    output o_bpu_ready, o_cmt_req, o_cmt_ghr, o_cmt_target, o_cmt_ghr_val
  );
endinterface

// File: rtl/xcore_if_bpu_ckpt.sv
// rtl/xcore_if_bpu_ckpt.sv - in-flight branch checkpoint queue and GHR update controller
//
// Purpose: records each BPU prediction with the GHR value before it, pops the
// oldest entry on resolution, and drives the GHR update port (correct or
// mispredict with restore value). Throttles the BPU when full and for the
// redirect cycle after a mispredict, and keeps saturating branch statistics.
// Ports:
//   i_sys_clk    clock, rising edge
//   i_sys_rst    synchronous active-low reset
//   bus          xcore_if_bpu_ckpt_if.slave: push / resolve / commit channels
//   o_cnt        current occupancy
//   o_err        sticky: resolution seen with an empty queue
//   o_br_total   committed branches, saturating
//   o_br_miss    mispredicted branches, saturating
module xcore_if_bpu_ckpt #(
  parameter int GHRLEN = 2,
  parameter int DEPTH  = 4,
  parameter int CNTW   = 16
) (
  input  logic                     i_sys_clk,
  input  logic                     i_sys_rst,
  xcore_if_bpu_ckpt_if.slave       bus,
  output logic [$clog2(DEPTH):0]   o_cnt,
  output logic                     o_err,
  output logic [CNTW-1:0]          o_br_total,
  output logic [CNTW-1:0]          o_br_miss
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic              taken;
    logic [GHRLEN-1:0] ghr_snap;
  } entry_t;

  entry_t mem [DEPTH];

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              cmt_req;
  logic              cmt_ghr;
  logic              cmt_target;
  logic [GHRLEN-1:0] cmt_ghr_val;

  logic   ready;
  logic   push;
  logic   pop;
  logic   miss;
  entry_t head;

  // cmt_ghr doubles as the mispredict pulse: it holds off pushes for the
  // single redirect cycle so no wrong-path prediction is recorded.
  assign ready = (count < FULL) && !cmt_ghr;
  assign push  = bus.i_bpu_req && ready;
  assign pop   = bus.i_wb_req && (count != '0);
  assign head  = mem[rd_ptr];
  assign miss  = head.taken != bus.i_wb_taken;

  // The top snapshot bit is shifted out of the restore value.
  logic unused_snap_msb;
  assign unused_snap_msb = head.ghr_snap[GHRLEN-1];

  // Storage needs no reset: pointers and count define what is valid, and a
  // write that is later dropped (flush/mispredict) is never read.
  always_ff @(posedge i_sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.i_bpu_taken, bus.i_ghr_val};
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cmt_req     <= 1'b0;
      cmt_ghr     <= 1'b0;
      cmt_target  <= 1'b0;
      cmt_ghr_val <= '0;
      o_err       <= 1'b0;
      o_br_total  <= '0;
      o_br_miss   <= '0;
    end else if (bus.i_wb_flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      cmt_req <= 1'b0;
      cmt_ghr <= 1'b0;
    end else begin
      cmt_req <= pop;
      cmt_ghr <= pop && miss;

      if (bus.i_wb_req && (count == '0)) begin
        o_err <= 1'b1;
      end

      if (pop) begin
        cmt_target  <= bus.i_wb_taken;
        cmt_ghr_val <= {head.ghr_snap[GHRLEN-2:0], bus.i_wb_taken};
        if (o_br_total != '1) begin
          o_br_total <= o_br_total + CNTW'(1);
        end
        if (miss && (o_br_miss != '1)) begin
          o_br_miss <= o_br_miss + CNTW'(1);
        end
      end

      if (pop && miss) begin
        // Everything younger than the mispredicted branch is wrong-path.
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  assign bus.o_bpu_ready   = ready;
  assign bus.o_cmt_req     = cmt_req;
  assign bus.o_cmt_ghr     = cmt_ghr;
  assign bus.o_cmt_target  = cmt_target;
  assign bus.o_cmt_ghr_val = cmt_ghr_val;
  assign o_cnt             = count;

endmodule

// File: tb/tb_xcore_if_bpu_ckpt.sv
// tb/tb_xcore_if_bpu_ckpt.sv - directed self-checking bench for xcore_if_bpu_ckpt
module tb_xcore_if_bpu_ckpt;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  cnt;
  logic        err;
  logic [15:0] total;
  logic [15:0] miss;

  int errors = 0;
  int checks = 0;

  logic [2:0] q [$];
  logic [2:0] ent;
  logic [1:0] exp_val;

  xcore_if_bpu_ckpt_if #(.GHRLEN(2)) bus ();

  xcore_if_bpu_ckpt #(.GHRLEN(2), .DEPTH(4), .CNTW(16)) dut (
    .i_sys_clk  (clk),
    .i_sys_rst  (rst),
    .bus        (bus),
    .o_cnt      (cnt),
    .o_err      (err),
    .o_br_total (total),
    .o_br_miss  (miss)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_bpu_req   = 1'b0;
    bus.i_bpu_taken = 1'b0;
    bus.i_ghr_val   = 2'b00;
    bus.i_wb_req    = 1'b0;
    bus.i_wb_taken  = 1'b0;
    bus.i_wb_flush  = 1'b0;
  endtask

  task automatic push(input logic t, input logic [1:0] g);
    bus.i_bpu_req   = 1'b1;
    bus.i_bpu_taken = t;
    bus.i_ghr_val   = g;
  endtask

  task automatic pop(input logic t);
    bus.i_wb_req   = 1'b1;
    bus.i_wb_taken = t;
  endtask

  initial begin
    idle();
    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      bus.i_bpu_req   = 1'($urandom);
      bus.i_bpu_taken = 1'($urandom);
      bus.i_ghr_val   = 2'($urandom);
      bus.i_wb_req    = 1'($urandom);
      bus.i_wb_taken  = 1'($urandom);
      bus.i_wb_flush  = 1'($urandom);
      step();
    end
    check("rst_cmt_req", bus.o_cmt_req, 0);
    check("rst_cmt_ghr", bus.o_cmt_ghr, 0);
    check("rst_cmt_target", bus.o_cmt_target, 0);
    check("rst_cmt_ghr_val", bus.o_cmt_ghr_val, 0);
    check("rst_cnt", cnt, 0);
    check("rst_err", err, 0);
    check("rst_total", total, 0);
    check("rst_miss", miss, 0);
    idle();
    #1;
    check("rst_ready", bus.o_bpu_ready, 1);
    rst = 1'b1;
    step();
    check("rel_cnt", cnt, 0);
    check("rel_ready", bus.o_bpu_ready, 1);
    check("rel_cmt_req", bus.o_cmt_req, 0);

    // Fill
    push(1, 2'b00); step();
    push(0, 2'b01); step();
    push(1, 2'b10); step();
    push(1, 2'b01); step();
    check("fill_cnt", cnt, 4);
    check("fill_ready", bus.o_bpu_ready, 0);
    push(0, 2'b11); step();
    check("fill_5th_cnt", cnt, 4);
    idle();

    // Correct commit of head (1,00)
    pop(1); step();
    check("ok_cmt_req", bus.o_cmt_req, 1);
    check("ok_cmt_ghr", bus.o_cmt_ghr, 0);
    check("ok_cmt_target", bus.o_cmt_target, 1);
    check("ok_cmt_ghr_val", bus.o_cmt_ghr_val, 2'b01);
    check("ok_cnt", cnt, 3);
    check("ok_total", total, 1);

    // Mispredict on head (0,01) with a concurrent push
    pop(1); push(0, 2'b11); step();
    idle();
    check("mis_cmt_req", bus.o_cmt_req, 1);
    check("mis_cmt_ghr", bus.o_cmt_ghr, 1);
    check("mis_cmt_ghr_val", bus.o_cmt_ghr_val, 2'b11);
    check("mis_cnt", cnt, 0);
    check("mis_ready", bus.o_bpu_ready, 0);
    check("mis_miss", miss, 1);
    check("mis_total", total, 2);
    step();
    check("mis_after_ready", bus.o_bpu_ready, 1);
    check("mis_after_cmt_req", bus.o_cmt_req, 0);
    check("mis_after_cmt_ghr", bus.o_cmt_ghr, 0);
    check("mis_after_cnt", cnt, 0);
    check("mis_hold_target", bus.o_cmt_target, 1);
    check("mis_hold_ghr_val", bus.o_cmt_ghr_val, 2'b11);

    // Wrap-around at occupancy 2
    push(1, 2'b10); step(); q.push_back(3'b110);
    push(0, 2'b11); step(); q.push_back(3'b011);
    for (int i = 0; i < 10; i++) begin
      ent     = q.pop_front();
      exp_val = {ent[0], ent[2]};
      pop(ent[2]);
      push(1'(i % 3 == 0), 2'(i));
      q.push_back({1'(i % 3 == 0), 2'(i)});
      step();
      check("wrap_cmt_req", bus.o_cmt_req, 1);
      check("wrap_cmt_ghr", bus.o_cmt_ghr, 0);
      check("wrap_target", bus.o_cmt_target, 32'(ent[2]));
      check("wrap_ghr_val", bus.o_cmt_ghr_val, 32'(exp_val));
      check("wrap_cnt", cnt, 2);
    end
    idle();
    // Drain
    while (q.size() != 0) begin
      ent = q.pop_front();
      pop(ent[2]);
      step();
      check("drain_ghr_val", bus.o_cmt_ghr_val, 32'({ent[0], ent[2]}));
    end
    idle();
    check("drain_cnt", cnt, 0);
    check("drain_total", total, 14);

    // Resolution with empty queue
    pop(1); step();
    idle();
    check("empty_cmt_req", bus.o_cmt_req, 0);
    check("empty_err", err, 1);
    check("empty_total", total, 14);
    step();
    check("err_sticky", err, 1);

    // Flush with occupancy 3 plus concurrent push and pop
    push(1, 2'b01); step();
    push(1, 2'b10); step();
    push(0, 2'b11); step();
    idle();
    check("pre_flush_cnt", cnt, 3);
    push(1, 2'b00); pop(1); bus.i_wb_flush = 1'b1; step();
    idle();
    check("flush_cnt", cnt, 0);
    check("flush_cmt_req", bus.o_cmt_req, 0);
    check("flush_total", total, 14);
    check("flush_miss", miss, 1);
    check("flush_ready", bus.o_bpu_ready, 1);

    // Saturation of o_br_total via back-to-back correct commits
    push(1, 2'b00); step();
    for (int i = 0; i < 65530; i++) begin
      push(1, 2'b00); pop(1); step();
    end
    idle();
    check("sat_total", total, 16'hFFFF);
    pop(1); step();
    idle();
    check("sat_total_hold", total, 16'hFFFF);
    check("sat_miss", miss, 1);
    check("sat_cnt", cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
